// File: rtl/ucr_pkg.sv
// Shared types and limits for the universal counter family.
package ucr_pkg;

  typedef enum logic [0:1] {
    UCR_LOAD = 2'b00,
    UCR_DEC  = 2'b01,
    UCR_INC  = 2'b10,
    UCR_HOLD = 2'b11
  } ucr_sel_t;

  localparam int unsigned UCR_MIN_WIDTH = 2;
  localparam int unsigned UCR_MAX_WIDTH = 36;

endpackage

// File: rtl/ucrn_tc.sv
// Combinational terminal-count and lookahead carry/borrow for one counter stage.
module ucrn_tc
  import ucr_pkg::*;
#(
  parameter int unsigned          WIDTH   = 4,
  parameter logic [WIDTH-1:0]     TERM_HI = '1
) (
  input  logic [WIDTH-1:0] q_i,
  input  ucr_sel_t         sel_i,
  input  logic             cin_i,
  output logic             tc_o,
  output logic             cout_o
);

  logic at_hi;
  logic at_lo;

  assign at_hi = (q_i == TERM_HI);
  assign at_lo = (q_i == '0);

  // Terminal count depends only on mode and Q; carry gates it with the enable.
  always_comb begin
    tc_o   = 1'b0;
    cout_o = 1'b0;
    case (sel_i)
      UCR_LOAD: begin
        tc_o   = 1'b1;
        cout_o = 1'b1;
      end
      UCR_DEC: begin
        tc_o   = at_lo;
        cout_o = cin_i & at_lo;
      end
      UCR_INC: begin
        tc_o   = at_hi;
        cout_o = cin_i & at_hi;
      end
      UCR_HOLD: begin
        tc_o   = 1'b0;
        cout_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ucrn_counter.sv
// WIDTH-bit universal up/down counter: load/dec/inc/hold, programmable modulus,
// wrap or saturate at terminal count, sticky wrap flag, lookahead carry out.
module ucrn_counter
  import ucr_pkg::*;
#(
  parameter int unsigned      WIDTH     = 4,
  parameter longint unsigned  MODULUS   = 64'd1 << WIDTH,
  parameter bit               SATURATE  = 1'b0,
  parameter longint unsigned  RESET_VAL = 64'd0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CLR,
  input  logic [0:WIDTH-1] D,
  input  logic [0:1]       SEL,
  input  logic             CIN,
  input  logic             WRAP_CLR,
  output logic [0:WIDTH-1] Q,
  output logic             COUT,
  output logic             TC,
  output logic             WRAP
);

  localparam longint unsigned  FULL_RANGE = 64'd1 << WIDTH;
  localparam logic [WIDTH-1:0] MAX_Q      = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] RST_Q      = WIDTH'(RESET_VAL);

  // Reject illegal parameterisations at elaboration.
  if (WIDTH < UCR_MIN_WIDTH || WIDTH > UCR_MAX_WIDTH) begin : g_bad_width
    $error("ucrn_counter: WIDTH out of range");
  end
  if (MODULUS < 64'd2 || MODULUS > FULL_RANGE) begin : g_bad_modulus
    $error("ucrn_counter: MODULUS out of range");
  end
  if (RESET_VAL >= MODULUS) begin : g_bad_reset_val
    $error("ucrn_counter: RESET_VAL must be below MODULUS");
  end

  ucr_sel_t         sel;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             wrap_q;
  logic             wrap_d;

  // Ascending-range ports map MSB-first onto the descending internal vectors.
  assign sel  = ucr_sel_t'(SEL);
  assign d    = D;
  assign Q    = q_q;
  assign WRAP = wrap_q;

  // Next count and sticky flag; clear dominates, a wrap set beats WRAP_CLR.
  always_comb begin
    q_d    = q_q;
    wrap_d = wrap_q;
    if (CLR) begin
      q_d    = '0;
      wrap_d = 1'b0;
    end else begin
      if (WRAP_CLR) wrap_d = 1'b0;
      case (sel)
        UCR_LOAD: q_d = (64'(d) < MODULUS) ? d : MAX_Q;
        UCR_DEC: begin
          if (CIN) begin
            if (q_q == '0) begin
              q_d    = SATURATE ? q_q : MAX_Q;
              wrap_d = 1'b1;
            end else begin
              q_d = q_q - WIDTH'(1);
            end
          end
        end
        UCR_INC: begin
          if (CIN) begin
            if (q_q == MAX_Q) begin
              q_d    = SATURATE ? q_q : '0;
              wrap_d = 1'b1;
            end else begin
              q_d = q_q + WIDTH'(1);
            end
          end
        end
        UCR_HOLD: q_d = q_q;
      endcase
    end
  end

  // Count and flag registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      q_q    <= RST_Q;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  ucrn_tc #(
    .WIDTH   (WIDTH),
    .TERM_HI (MAX_Q)
  ) u_tc (
    .q_i    (q_q),
    .sel_i  (sel),
    .cin_i  (CIN),
    .tc_o   (TC),
    .cout_o (COUT)
  );

endmodule

// File: tb/tb_ucrn_counter.sv
// Directed self-checking bench for ucrn_counter: plain wrap, non-binary modulus,
// saturating mode with nonzero reset value, and a two-stage cascade.
module tb_ucrn_counter;
  import ucr_pkg::*;

  logic clk;
  logic rst;

  // Instance A: WIDTH=4, full modulus, wrap
  logic       a_clr, a_cin, a_wclr;
  ucr_sel_t   a_sel;
  logic [0:3] a_d, a_q;
  logic       a_cout, a_tc, a_wrap;

  // Instance B: WIDTH=6, MODULUS=40, wrap
  logic       b_clr, b_cin, b_wclr;
  ucr_sel_t   b_sel;
  logic [0:5] b_d, b_q;
  logic       b_cout, b_tc, b_wrap;

  // Instance C: WIDTH=4, MODULUS=10, saturate, RESET_VAL=3
  logic       c_clr, c_cin, c_wclr;
  ucr_sel_t   c_sel;
  logic [0:3] c_d, c_q;
  logic       c_cout, c_tc, c_wrap;

  // Cascade: lo COUT drives hi CIN
  ucr_sel_t   k_sel;
  logic       lo_cin;
  logic [0:3] lo_d, lo_q, hi_d, hi_q;
  logic       lo_cout, lo_tc, lo_wrap, hi_cout, hi_tc, hi_wrap;

  int n_total = 0;
  int n_pass  = 0;

  ucrn_counter #(.WIDTH(4)) u_a (
    .CLK(clk), .RESET(rst), .CLR(a_clr), .D(a_d), .SEL(a_sel), .CIN(a_cin),
    .WRAP_CLR(a_wclr), .Q(a_q), .COUT(a_cout), .TC(a_tc), .WRAP(a_wrap));

  ucrn_counter #(.WIDTH(6), .MODULUS(40), .SATURATE(1'b0)) u_b (
    .CLK(clk), .RESET(rst), .CLR(b_clr), .D(b_d), .SEL(b_sel), .CIN(b_cin),
    .WRAP_CLR(b_wclr), .Q(b_q), .COUT(b_cout), .TC(b_tc), .WRAP(b_wrap));

  ucrn_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1), .RESET_VAL(3)) u_c (
    .CLK(clk), .RESET(rst), .CLR(c_clr), .D(c_d), .SEL(c_sel), .CIN(c_cin),
    .WRAP_CLR(c_wclr), .Q(c_q), .COUT(c_cout), .TC(c_tc), .WRAP(c_wrap));

  ucrn_counter #(.WIDTH(4)) u_lo (
    .CLK(clk), .RESET(rst), .CLR(1'b0), .D(lo_d), .SEL(k_sel), .CIN(lo_cin),
    .WRAP_CLR(1'b0), .Q(lo_q), .COUT(lo_cout), .TC(lo_tc), .WRAP(lo_wrap));

  ucrn_counter #(.WIDTH(4)) u_hi (
    .CLK(clk), .RESET(rst), .CLR(1'b0), .D(hi_d), .SEL(k_sel), .CIN(lo_cout),
    .WRAP_CLR(1'b0), .Q(hi_q), .COUT(hi_cout), .TC(hi_tc), .WRAP(hi_wrap));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_clr = 0; a_cin = 0; a_wclr = 0; a_sel = UCR_HOLD; a_d = '0;
    b_clr = 0; b_cin = 0; b_wclr = 0; b_sel = UCR_HOLD; b_d = '0;
    c_clr = 0; c_cin = 0; c_wclr = 0; c_sel = UCR_HOLD; c_d = '0;
    k_sel = UCR_HOLD; lo_cin = 0; lo_d = '0; hi_d = '0;
    #12;
    chk("rst_a_q", 64'(a_q), 64'd0);
    chk("rst_c_q", 64'(c_q), 64'd3);
    chk("rst_a_wrap", 64'(a_wrap), 64'd0);
    rst = 1'b0;

    // --- A: set WRAP, count to 7, then async reset mid-cycle
    a_sel = UCR_LOAD; a_d = 4'hF; c_sel = UCR_LOAD; c_d = 4'd5; tick();
    chk("a_ld_f", 64'(a_q), 64'hF);
    chk("c_ld_5", 64'(c_q), 64'd5);
    c_sel = UCR_HOLD;
    a_sel = UCR_INC; a_cin = 1; tick();
    chk("a_wrap_q", 64'(a_q), 64'd0);
    chk("a_wrap_set", 64'(a_wrap), 64'd1);
    a_sel = UCR_LOAD; a_d = 4'd7; a_cin = 0; tick();
    chk("a_ld_7", 64'(a_q), 64'd7);
    a_sel = UCR_HOLD;
    #1 rst = 1'b1;
    #1;
    chk("async_a_q", 64'(a_q), 64'd0);
    chk("async_a_wrap", 64'(a_wrap), 64'd0);
    chk("async_c_q", 64'(c_q), 64'd3);
    #1 rst = 1'b0;

    // --- A: load 0xE, two increments
    a_sel = UCR_LOAD; a_d = 4'hE; tick();
    chk("a_ld_e", 64'(a_q), 64'hE);
    a_sel = UCR_INC; a_cin = 1; #1;
    chk("a_tc_e", 64'(a_tc), 64'd0);
    chk("a_cout_e", 64'(a_cout), 64'd0);
    tick();
    chk("a_inc_f", 64'(a_q), 64'hF);
    chk("a_wrap_pre", 64'(a_wrap), 64'd0);
    chk("a_tc_f", 64'(a_tc), 64'd1);
    chk("a_cout_f", 64'(a_cout), 64'd1);
    a_cin = 0; #1;
    chk("a_cout_nocin", 64'(a_cout), 64'd0);
    chk("a_tc_nocin", 64'(a_tc), 64'd1);
    a_cin = 1; tick();
    chk("a_inc_0", 64'(a_q), 64'd0);
    chk("a_wrap_post", 64'(a_wrap), 64'd1);
    chk("a_tc_0", 64'(a_tc), 64'd0);

    // --- A: WRAP_CLR collisions
    a_sel = UCR_LOAD; a_d = 4'hF; a_cin = 0; tick();
    a_sel = UCR_HOLD; a_wclr = 1; tick();
    chk("wclr_alone1", 64'(a_wrap), 64'd0);
    a_sel = UCR_INC; a_cin = 1; a_wclr = 1; tick();
    chk("wclr_vs_set_q", 64'(a_q), 64'd0);
    chk("wclr_vs_set", 64'(a_wrap), 64'd1);
    a_sel = UCR_HOLD; a_cin = 0; a_wclr = 1; tick();
    chk("wclr_alone2", 64'(a_wrap), 64'd0);
    a_wclr = 0;

    // --- A: CLR beats LOAD
    a_sel = UCR_LOAD; a_d = 4'hF; tick();
    a_sel = UCR_INC; a_cin = 1; tick();
    a_sel = UCR_LOAD; a_d = 4'd3; a_cin = 0; tick();
    chk("pre_clr_q", 64'(a_q), 64'd3);
    chk("pre_clr_wrap", 64'(a_wrap), 64'd1);
    a_clr = 1; a_sel = UCR_LOAD; a_d = 4'd5; tick();
    chk("clr_q", 64'(a_q), 64'd0);
    chk("clr_wrap", 64'(a_wrap), 64'd0);
    a_clr = 0;

    // --- A: HOLD ten cycles with CIN toggling
    a_sel = UCR_LOAD; a_d = 4'd9; tick();
    a_sel = UCR_HOLD;
    for (int i = 0; i < 10; i++) begin
      a_cin = i[0]; #1;
      chk("hold_tc", 64'(a_tc), 64'd0);
      chk("hold_cout", 64'(a_cout), 64'd0);
      tick();
    end
    chk("hold_q", 64'(a_q), 64'd9);
    a_sel = UCR_LOAD; a_cin = 0; #1;
    chk("load_cout_c0", 64'(a_cout), 64'd1);
    chk("load_tc", 64'(a_tc), 64'd1);
    a_cin = 1; #1;
    chk("load_cout_c1", 64'(a_cout), 64'd1);
    a_sel = UCR_DEC; #1;
    chk("dec_tc_9", 64'(a_tc), 64'd0);
    tick();
    chk("dec_8", 64'(a_q), 64'd8);
    a_sel = UCR_HOLD; a_cin = 0;

    // --- B: modulus 40
    b_sel = UCR_LOAD; b_d = 6'd20; tick();
    chk("b_ld_20", 64'(b_q), 64'd20);
    b_d = 6'd50; tick();
    chk("b_ld_clamp", 64'(b_q), 64'd39);
    b_sel = UCR_INC; b_cin = 1; #1;
    chk("b_cout_39", 64'(b_cout), 64'd1);
    tick();
    chk("b_inc_wrap_q", 64'(b_q), 64'd0);
    chk("b_inc_wrap", 64'(b_wrap), 64'd1);
    b_sel = UCR_HOLD; b_wclr = 1; tick();
    chk("b_wclr", 64'(b_wrap), 64'd0);
    b_wclr = 0; b_sel = UCR_DEC; #1;
    chk("b_dec_tc_0", 64'(b_tc), 64'd1);
    tick();
    chk("b_dec_wrap_q", 64'(b_q), 64'd39);
    chk("b_dec_wrap", 64'(b_wrap), 64'd1);
    tick();
    chk("b_dec_38", 64'(b_q), 64'd38);
    b_sel = UCR_HOLD; b_cin = 0;

    // --- C: saturating, modulus 10
    c_sel = UCR_LOAD; c_d = 4'd12; tick();
    chk("c_ld_clamp", 64'(c_q), 64'd9);
    c_d = 4'd8; tick();
    chk("c_ld_8", 64'(c_q), 64'd8);
    c_sel = UCR_INC; c_cin = 1; tick();
    chk("c_inc_9", 64'(c_q), 64'd9);
    chk("c_wrap_pre", 64'(c_wrap), 64'd0);
    chk("c_tc_9", 64'(c_tc), 64'd1);
    chk("c_cout_9", 64'(c_cout), 64'd1);
    tick();
    chk("c_sat_9a", 64'(c_q), 64'd9);
    chk("c_sat_wrap", 64'(c_wrap), 64'd1);
    tick();
    chk("c_sat_9b", 64'(c_q), 64'd9);
    c_sel = UCR_HOLD; c_cin = 0; c_wclr = 1; tick();
    chk("c_wclr", 64'(c_wrap), 64'd0);
    c_wclr = 0; c_sel = UCR_LOAD; c_d = 4'd0; tick();
    c_sel = UCR_DEC; c_cin = 1; tick();
    chk("c_dec_sat_q", 64'(c_q), 64'd0);
    chk("c_dec_sat_wrap", 64'(c_wrap), 64'd1);
    c_sel = UCR_INC; c_cin = 0; tick();
    chk("c_inc_nocin", 64'(c_q), 64'd0);
    c_sel = UCR_HOLD;

    // --- Cascade
    k_sel = UCR_LOAD; lo_d = 4'hF; hi_d = 4'h0; tick();
    chk("k_ld_lo", 64'(lo_q), 64'hF);
    chk("k_ld_hi", 64'(hi_q), 64'h0);
    k_sel = UCR_INC; lo_cin = 1; #1;
    chk("k_hi_cout_0f", 64'(hi_cout), 64'd0);
    tick();
    chk("k_0f_lo", 64'(lo_q), 64'h0);
    chk("k_0f_hi", 64'(hi_q), 64'h1);
    k_sel = UCR_LOAD; lo_d = 4'hF; hi_d = 4'hF; tick();
    k_sel = UCR_INC; #1;
    chk("k_lo_cout_ff", 64'(lo_cout), 64'd1);
    chk("k_hi_cout_ff", 64'(hi_cout), 64'd1);
    tick();
    chk("k_ff_lo", 64'(lo_q), 64'h0);
    chk("k_ff_hi", 64'(hi_q), 64'h0);
    chk("k_ff_hi_wrap", 64'(hi_wrap), 64'd1);
    k_sel = UCR_HOLD; lo_cin = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
